pcpu_mdu: RTL and testbench
===========================

// Module: pcpu_mdu
// PURPOSE
//  Iterative multiply/divide unit with HI/LO registers for the pipelined CPU.
//  Sits beside the EX-stage ALU; executes MULT/MULTU/DIV/DIVU over several cycles.
//  Raises a stall request to the hazard unit while a later instruction needs it.
//  Generalises the single-cycle 64-bit ALU product to any XLEN, adds division and kill.
// PARAMETERS
//  XLEN   32  operand width; HI and LO are each XLEN bits; must be even and >= 8
//  CNT_W  $clog2(XLEN)+1  iteration counter width (derived, do not override)
// PORTS
//  clk          in   1     rising-edge clock
//  reset        in   1     asynchronous, active-low reset
//  start_i      in   1     EX holds an MDU op this cycle
//  op_i         in   3     mdu_op_t: MULT, MULTU, DIV, DIVU, MTHI, MTLO
//  a_i          in   XLEN  rs operand (forwarded); dividend / MT source
//  b_i          in   XLEN  rt operand (forwarded); divisor
//  kill_i       in   1     abort in-flight op (exception/flush)
//  mf_i         in   1     MFHI/MFLO sits in EX this cycle
//  busy_o       out  1     registered; high in RUN and FIX
//  done_o       out  1     registered one-cycle pulse; HI/LO are new in this cycle
//  stall_req_o  out  1     comb: busy_o & (start_i | mf_i)
//  hi_o         out  XLEN  HI register
//  lo_o         out  XLEN  LO register
// BEHAVIOUR
//  Reset: state IDLE, busy_o=0, done_o=0, hi_o=0, lo_o=0, counter=0.
//  FSM IDLE -> RUN -> FIX -> IDLE.
//  IDLE: start_i & MULT/MULTU/DIV/DIVU latches |a|,|b|, signs, op; goes to RUN.
//  IDLE: start_i & MTHI/MTLO writes a_i to HI/LO at that edge; no busy, no done.
//  RUN: exactly XLEN cycles, one bit per cycle.
//   Multiply: unsigned shift-add.
//   Divide: unsigned restoring, one divstep per cycle.
//  FIX: one cycle. Applies sign correction, writes HI/LO, returns to IDLE.
//   Product negated if sign(a)^sign(b) (signed ops only).
//   Quotient negated if sign(a)^sign(b); remainder takes sign of a.
//  Latency: start sampled at edge 0; busy_o high in cycles 1..XLEN+1; done_o in XLEN+2.
//  A new start is accepted in the done_o cycle (back-to-back ops allowed).
//  start_i while busy is ignored; the hazard unit holds EX via stall_req_o.
//  Divide by zero (signed or unsigned): HI=a_i, LO=all ones; full latency, no trap.
//  Signed MIN / -1: LO=MIN, HI=0 (falls out of unsigned path plus negate).
//  kill_i in any state: next state IDLE, busy_o=0, no done_o, HI/LO unchanged.
//  kill_i with start_i in the same cycle: kill wins and nothing is accepted.
//  kill_i during FIX: HI/LO write suppressed.
//  Reset asserted mid-operation: immediate return to reset values.
// CONFIGURATION
//  MDU_DIV_EN defined: full divider as above.
//  MDU_DIV_EN undefined: no divider logic.
//   DIV/DIVU accepted in IDLE; done_o pulses in the next cycle.
//   busy_o stays 0; HI/LO unchanged.
// STRUCTURE
//  pcpu_pkg: mdu_op_t enum (MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5).
//  pcpu_pkg: mdu_state_t (IDLE, RUN, FIX).
//  Sub-module pcpu_mdu_divstep: combinational one-bit restoring step.
//   Ports: rem_in, quo_in, divisor -> rem_out, quo_out; only under MDU_DIV_EN.
//  Multiply and divide share the {acc, q} 2*XLEN shift register.
// TESTING (XLEN=32)
//  MULT a=0xFFFFFFFD, b=7 -> busy 33 cycles; done_o at cycle 34.
//   Result: HI=0xFFFFFFFF, LO=0xFFFFFFEB.
//  MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
//  DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//  DIVU 7/0 -> HI=0x00000007, LO=0xFFFFFFFF.
//  DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
//  MULT then kill_i in RUN cycle 10 -> busy_o=0 next cycle; no done_o; HI/LO retain old.
//   Then MTHI 0x12345678 -> hi_o=0x12345678 next cycle.
//  MULT busy plus mf_i=1 -> stall_req_o=1 until done_o cycle.
//   Second start_i during busy is ignored; HI/LO reflect first op only.

Source files
------------

// File: rtl/pcpu_pkg.sv
// Shared types for the pcpu multiply/divide unit: op encoding and FSM states.
package pcpu_pkg;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } mdu_state_t;

    function automatic logic is_signed_op(mdu_op_t op);
        return (op == MULT) || (op == DIV);
    endfunction

endpackage

// File: rtl/pcpu_mdu_divstep.sv
// One restoring-division step: shift in the next dividend bit, subtract if it fits.
module pcpu_mdu_divstep #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    logic          fits;

    always_comb begin
        shifted = {rem_in, quo_in[XLEN-1]};
        diff    = shifted - {1'b0, divisor};
        // Borrow out of the top bit means the divisor did not fit.
        fits    = ~diff[XLEN];
        rem_out = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quo_out = {quo_in[XLEN-2:0], fits};
    end

endmodule

// File: rtl/pcpu_mdu.sv
// Iterative multiply/divide unit with HI/LO registers; one result bit per RUN cycle.
// Define MDU_DIV_EN to build the divider; otherwise DIV/DIVU complete at once as no-ops.
module pcpu_mdu
    import pcpu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            kill_i,
    input  logic            mf_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            stall_req_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    localparam int unsigned       CNT_W   = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(XLEN - 1);

    mdu_op_t         op;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_abs, b_abs;

    mdu_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] acc_q, acc_d, q_q, q_d, b_q, b_d;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
    logic            neg_q, neg_d, busy_q, busy_d, done_q, done_d;

    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   step_acc, step_q, res_hi, res_lo;
    logic [2*XLEN-1:0] prod_fix;
    logic              load_run;

    assign op    = mdu_op_t'(op_i);
    assign a_neg = is_signed_op(op) & a_i[XLEN-1];
    assign b_neg = is_signed_op(op) & b_i[XLEN-1];
    assign a_abs = a_neg ? -a_i : a_i;
    assign b_abs = b_neg ? -b_i : b_i;

`ifdef MDU_DIV_EN
    logic            is_div_q, is_div_d, neg_rem_q, neg_rem_d, div0_q, div0_d;
    logic [XLEN-1:0] div_rem, div_quo;

    pcpu_mdu_divstep #(
        .XLEN (XLEN)
    ) u_divstep (
        .rem_in  (acc_q),
        .quo_in  (q_q),
        .divisor (b_q),
        .rem_out (div_rem),
        .quo_out (div_quo)
    );
`endif

    // {acc, q} is the shared 2*XLEN shift register for product or remainder/quotient.
    always_comb begin
        mul_sum  = {1'b0, acc_q} + (q_q[0] ? {1'b0, b_q} : '0);
        step_acc = mul_sum[XLEN:1];
        step_q   = {mul_sum[0], q_q[XLEN-1:1]};
        prod_fix = neg_q ? -{acc_q, q_q} : {acc_q, q_q};
        res_hi   = prod_fix[2*XLEN-1:XLEN];
        res_lo   = prod_fix[XLEN-1:0];
`ifdef MDU_DIV_EN
        if (is_div_q) begin
            step_acc = div_rem;
            step_q   = div_quo;
            res_hi   = neg_rem_q ? -acc_q : acc_q;
            res_lo   = div0_q ? '1 : (neg_q ? -q_q : q_q);
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        q_d      = q_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        neg_d    = neg_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        load_run = 1'b0;
`ifdef MDU_DIV_EN
        is_div_d  = is_div_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
`endif
        if (kill_i) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        case (op)
                            MULT, MULTU, DIV, DIVU: begin
`ifdef MDU_DIV_EN
                                load_run = 1'b1;
`else
                                load_run = (op == MULT) || (op == MULTU);
                                done_d   = ~load_run;
`endif
                            end
                            MTHI:    hi_d = a_i;
                            MTLO:    lo_d = a_i;
                            default: ;
                        endcase
                    end
                    if (load_run) begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                        cnt_d   = '0;
                        acc_d   = '0;
                        q_d     = a_abs;
                        b_d     = b_abs;
                        neg_d   = a_neg ^ b_neg;
`ifdef MDU_DIV_EN
                        is_div_d  = (op == DIV) || (op == DIVU);
                        neg_rem_d = a_neg;
                        div0_d    = (b_i == '0);
`endif
                    end
                end
                RUN: begin
                    acc_d = step_acc;
                    q_d   = step_q;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CntLast) begin
                        state_d = FIX;
                    end
                end
                FIX: begin
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MDU_DIV_EN
            is_div_q  <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef MDU_DIV_EN
            is_div_q  <= is_div_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
`endif
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;
    assign stall_req_o = busy_q & (start_i | mf_i);

endmodule

// File: tb/tb_pcpu_mdu.sv
// Scoreboard bench for pcpu_mdu (XLEN=32); divide vectors depend on MDU_DIV_EN.
module tb_pcpu_mdu;
    import pcpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, start_i, kill_i, mf_i;
    logic [2:0]  op_i;
    logic [31:0] a_i, b_i, hi_o, lo_o;
    logic        busy_o, done_o, stall_req_o;

    int          total = 0;
    int          bad = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t mul_vecs [6] = '{
        '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001},
        '{MULT,  32'h00000005, 32'h00000006, 32'h00000000, 32'h0000001E},
        '{MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001},
        '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000},
        '{MULTU, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000},
        '{MULT,  32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hEDCBA988}
    };

    vec_t div_vecs [7] = '{
        '{DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD},
        '{DIVU, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF},
        '{DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
        '{DIVU, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E},
        '{DIV,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD},
        '{DIV,  32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF},
        '{DIVU, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF}
    };

    pcpu_mdu #(
        .XLEN (32)
    ) dut (
        .clk         (clk),
        .reset       (rst_n),
        .start_i     (start_i),
        .op_i        (op_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .kill_i      (kill_i),
        .mf_i        (mf_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .stall_req_o (stall_req_o),
        .hi_o        (hi_o),
        .lo_o        (lo_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done_o pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && done_o) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done_o=1 expected 0");
            end else begin
                mon_exp = exp_q.pop_front();
                check("result_hi_lo", {hi_o, lo_o}, mon_exp);
            end
        end
    end

    task automatic issue_now(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        issue_now(op, a, b);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int lat, input int nbusy, input bit now);
        int n;
        int nb;
        exp_q.push_back(exp);
        {model_hi, model_lo} = exp;
        if (now) issue_now(op, a, b);
        else issue(op, a, b);
        n  = 0;
        nb = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy_o) nb++;
        end while (!done_o && n < 100);
        check("latency", n, lat);
        check("busy_cycles", nb, nbusy);
    endtask

    initial begin
        int n;
        int dcnt;
        rst_n   = 1'b0;
        start_i = 1'b0;
        kill_i  = 1'b0;
        mf_i    = 1'b0;
        op_i    = '0;
        a_i     = '0;
        b_i     = '0;

        #12;
        mf_i = 1'b1;
        #1;
        check("reset_busy", busy_o, 0);
        check("reset_done", done_o, 0);
        check("reset_hi", hi_o, 0);
        check("reset_lo", lo_o, 0);
        check("reset_stall", stall_req_o, 0);
        mf_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        run_op(MULT, 32'hFFFFFFFD, 32'h7, {32'hFFFFFFFF, 32'hFFFFFFEB}, 34, 33, 1'b0);
        // Back-to-back: first vector is started in the previous op's done cycle.
        for (int i = 0; i < 6; i++) begin
            run_op(mul_vecs[i].op, mul_vecs[i].a, mul_vecs[i].b,
                   {mul_vecs[i].hi, mul_vecs[i].lo}, 34, 33, (i % 2) == 0);
        end

        for (int i = 0; i < 7; i++) begin
`ifdef MDU_DIV_EN
            run_op(div_vecs[i].op, div_vecs[i].a, div_vecs[i].b,
                   {div_vecs[i].hi, div_vecs[i].lo}, 34, 33, 1'b0);
`else
            run_op(div_vecs[i].op, div_vecs[i].a, div_vecs[i].b,
                   {model_hi, model_lo}, 1, 0, 1'b0);
`endif
        end

        issue(MTHI, 32'hCAFEF00D, 32'h0);
        model_hi = 32'hCAFEF00D;
        check("mthi", hi_o, model_hi);
        issue(MTLO, 32'h0BADBEEF, 32'h0);
        model_lo = 32'h0BADBEEF;
        check("mtlo", lo_o, model_lo);
        check("mt_no_busy", busy_o, 0);

        // Kill in RUN cycle 10.
        issue(MULT, 32'h3, 32'h4);
        repeat (9) @(posedge clk);
        #1;
        kill_i = 1'b1;
        @(posedge clk);
        #1;
        kill_i = 1'b0;
        check("kill_run_busy", busy_o, 0);
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_o) dcnt++;
        end
        check("kill_run_no_done", dcnt, 0);
        check("kill_run_hi_lo", {hi_o, lo_o}, {model_hi, model_lo});
        issue(MTHI, 32'h12345678, 32'h0);
        model_hi = 32'h12345678;
        check("mthi_after_kill", hi_o, model_hi);

        // Kill during FIX suppresses the write.
        issue(MULT, 32'h3, 32'h4);
        repeat (32) @(posedge clk);
        #1;
        check("fix_busy", busy_o, 1);
        kill_i = 1'b1;
        @(posedge clk);
        #1;
        kill_i = 1'b0;
        check("kill_fix_busy", busy_o, 0);
        dcnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (done_o) dcnt++;
        end
        check("kill_fix_no_done", dcnt, 0);
        check("kill_fix_hi_lo", {hi_o, lo_o}, {model_hi, model_lo});

        // Kill and start together: nothing accepted.
        @(posedge clk);
        #1;
        kill_i  = 1'b1;
        start_i = 1'b1;
        op_i    = MULT;
        a_i     = 32'h3;
        b_i     = 32'h4;
        @(posedge clk);
        #1;
        check("kill_start_busy", busy_o, 0);
        op_i = MTLO;
        a_i  = 32'h55555555;
        @(posedge clk);
        #1;
        kill_i  = 1'b0;
        start_i = 1'b0;
        check("kill_start_lo", lo_o, model_lo);

        // Stall while busy with MF in EX and a second start that must be ignored.
        exp_q.push_back({32'h1, 32'h0});
        {model_hi, model_lo} = {32'h1, 32'h0};
        issue(MULTU, 32'h00010000, 32'h00010000);
        start_i = 1'b1;
        op_i    = MTHI;
        a_i     = 32'hDEADBEEF;
        mf_i    = 1'b1;
        n       = 0;
        do begin
            @(negedge clk);
            n++;
            if (done_o) begin
                check("stall_done_cycle", stall_req_o, 0);
                start_i = 1'b0;
                mf_i    = 1'b0;
            end else begin
                check("stall_busy", stall_req_o, 1);
            end
        end while (!done_o && n < 100);
        start_i = 1'b0;
        mf_i    = 1'b0;
        check("stall_latency", n, 34);
        @(posedge clk);
        #1;
        check("ignored_start_hi", hi_o, model_hi);

        // Asynchronous reset mid-operation.
        issue(MULT, 32'h3, 32'h4);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_busy", busy_o, 0);
        check("midreset_hi_lo", {hi_o, lo_o}, 64'h0);
        model_hi = '0;
        model_lo = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_op(MULT, 32'h5, 32'h6, {32'h0, 32'h1E}, 34, 33, 1'b0);

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
